mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MIPS memory-access stage. Sits directly downstream of the EX/MEM pipeline latch and consumes its outputs.
- Resolves branch/jump PC redirection.
- Performs load/store transactions on a req/ack data-memory bus, stalling upstream until the transaction completes.
- Holds the MEM/WB pipeline register that feeds write-back.

Parameters:
- TIMEOUT_CYCLES, 16: max ACCESS cycles without dmem_ack before the transaction is aborted.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX/MEM latch holds a real instruction.
- branch, jump, MemRead, MemWrite, RegWrite, MemtoReg  in  1 each  control bits from EX/MEM.
- adder  in  32  branch/jump target.
- aluzero  in  2  bit0 = ALU zero flag; bit1 reserved, ignored.
- alu  in  32  ALU result / memory byte address.
- readdata2  in  32  store data.
- mux  in  5  destination register number.
- pc_sel  out  2  00 = sequential, 01 = branch target, 10 = jump target.
- pc_target  out  32  equals adder.
- flush  out  1  pc_sel != 00; squashes younger stages.
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- dmem_req  out  1  bus request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned byte address.
- dmem_wdata  out  32  write data.
- dmem_rdata  in  32  read data; valid when dmem_ack = 1.
- dmem_ack  in  1  transaction complete, single-cycle pulse.
- bus_err  out  1  one-cycle pulse on timeout abort.
- wb_valid, RegWrite_wb, MemtoReg_wb  out  1 each  MEM/WB register outputs.
- readdata_wb  out  32  MEM/WB register output.
- alu_wb  out  32  MEM/WB register output.
- mux_wb  out  5  MEM/WB register output.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE, counter = 0.
  - All registered outputs = 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, bus_err, and all *_wb.
  - Reset mid-ACCESS drops dmem_req immediately. No write-back occurs.
- PC redirection (combinational, ex_valid qualified):
  - jump = 1 → pc_sel = 10.
  - else branch = 1 and aluzero[0] = 1 → pc_sel = 01.
  - else pc_sel = 00. Jump has priority over branch.
  - pc_target = adder always.
- mem_op = ex_valid & (MemRead | MemWrite). If both MemRead and MemWrite are set, the access is a write (MemWrite wins).
- FSM states: IDLE, ACCESS.
- IDLE, mem_op = 0:
  - mem_stall = 0.
  - MEM/WB loads at the edge: wb_valid = ex_valid, RegWrite_wb = RegWrite & ex_valid, MemtoReg_wb, alu_wb = alu, mux_wb = mux, readdata_wb unchanged.
  - Latency 1 cycle.
- IDLE, mem_op = 1:
  - mem_stall = 1 (combinational).
  - At the edge: dmem_req = 1, dmem_we = MemWrite, dmem_addr = {alu[31:2], 2'b00}, dmem_wdata = readdata2, counter = 0, state → ACCESS.
  - MEM/WB loads a bubble (wb_valid = 0, RegWrite_wb = 0).
- ACCESS:
  - dmem_addr, dmem_we and dmem_wdata are held stable while dmem_req = 1.
  - mem_stall = ~dmem_ack & (counter != TIMEOUT_CYCLES-1).
  - dmem_ack = 1 at an edge:
    - dmem_req = 0, state → IDLE.
    - MEM/WB loads: readdata_wb = dmem_rdata (loads only; unchanged for stores), RegWrite_wb = RegWrite, alu_wb, mux_wb, MemtoReg_wb, wb_valid = 1.
    - Upstream advances at the same edge.
  - No ack and counter = TIMEOUT_CYCLES-1:
    - Abort: dmem_req = 0, bus_err = 1 for one cycle, state → IDLE.
    - MEM/WB loads with RegWrite_wb = 0, wb_valid = 1.
  - No ack otherwise: counter increments.
- Minimum load/store latency is 2 cycles (ack in the first ACCESS cycle).
- An ack arriving while in IDLE is ignored.
- mem_stall is never asserted for non-memory instructions.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: in IDLE, a mem_op with alu[1:0] != 00:
  - issues no bus request;
  - pulses bus_err for one cycle;
  - loads MEM/WB with RegWrite_wb = 0, wb_valid = 1;
  - 1-cycle latency, no stall.
- Undefined: the low address bits are silently forced to 00 and the access proceeds.

Decomposition:
- Shared package mips_pkg holds:
  - PC_SEQ = 2'b00, PC_BR = 2'b01, PC_JMP = 2'b10;
  - state enum {IDLE, ACCESS};
  - XLEN = 32, REG_AW = 5.
- One natural sub-module: mem_wb_reg, the MEM/WB register with load enable and async active-low clear.

Test Plan:
- Load, alu = 0x100, ack in first ACCESS cycle with rdata = 0xDEADBEEF → mem_stall high for 1 cycle; readdata_wb = 0xDEADBEEF, RegWrite_wb = 1, wb_valid = 1 two edges after issue.
- Store, alu = 0x204, readdata2 = 0x12345678, ack after 3 cycles → dmem_we = 1, addr/wdata stable for 3 cycles; stall for 3 cycles; RegWrite_wb = 0.
- No ack, TIMEOUT_CYCLES = 16 → dmem_req dropped after 16 ACCESS cycles; bus_err pulse; RegWrite_wb = 0.
- Branch with aluzero = 01, adder = 0x40 → pc_sel = 01, flush = 1. Branch + jump together → pc_sel = 10. Branch with aluzero = 00 → pc_sel = 00.
- rst_n low mid-ACCESS → dmem_req = 0 immediately; state IDLE; all *_wb = 0; a late ack is ignored.
- With MEM_ALIGN_CHECK_EN, load at alu = 0x102 → no dmem_req, bus_err pulse, RegWrite_wb = 0. Without the macro → access issued to 0x100.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants for the memory stage.
package mips_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   // Control and datapath fields of MEM/WB that load together.
   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic              mem_to_reg;
      logic [XLEN-1:0]   alu;
      logic [REG_AW-1:0] mux;
   } wb_ctl_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Control/ALU fields and the load-data field have
// separate load enables so stores and aborts leave readdata untouched.
module mem_wb_reg
   import mips_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ld,
   input  wb_ctl_t         d,
   input  logic            rd_ld,
   input  logic [XLEN-1:0] rd_d,
   output wb_ctl_t         q,
   output logic [XLEN-1:0] rd_q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q    <= '0;
         rd_q <= '0;
      end else begin
         if (ld)    q    <= d;
         if (rd_ld) rd_q <= rd_d;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: PC redirection, req/ack data-memory access with
// timeout abort, and the MEM/WB register. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_stage
   import mips_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic              branch,
   input  logic              jump,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              RegWrite,
   input  logic              MemtoReg,
   input  logic [XLEN-1:0]   adder,
   input  logic [1:0]        aluzero,
   input  logic [XLEN-1:0]   alu,
   input  logic [XLEN-1:0]   readdata2,
   input  logic [REG_AW-1:0] mux,
   output logic [1:0]        pc_sel,
   output logic [XLEN-1:0]   pc_target,
   output logic              flush,
   output logic              mem_stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [XLEN-1:0]   dmem_addr,
   output logic [XLEN-1:0]   dmem_wdata,
   input  logic [XLEN-1:0]   dmem_rdata,
   input  logic              dmem_ack,
   output logic              bus_err,
   output logic              wb_valid,
   output logic              RegWrite_wb,
   output logic              MemtoReg_wb,
   output logic [XLEN-1:0]   readdata_wb,
   output logic [XLEN-1:0]   alu_wb,
   output logic [REG_AW-1:0] mux_wb,
   output state_t            state_dbg
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic            mem_op, misalign;
   logic            start, finish, cnt_inc, err_set;
   logic            wb_ld, rd_ld;
   wb_ctl_t         wb_d, wb_q;
   logic            unused_az;

   assign unused_az = aluzero[1];

   always_comb begin
      pc_sel = PC_SEQ;
      if (ex_valid && jump)
         pc_sel = PC_JMP;
      else if (ex_valid && branch && aluzero[0])
         pc_sel = PC_BR;
   end

   assign pc_target = adder;
   assign flush     = (pc_sel != PC_SEQ);

   assign mem_op = ex_valid & (MemRead | MemWrite);

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign = (alu[1:0] != 2'b00);
`else
   logic unused_lo;
   assign misalign  = 1'b0;
   assign unused_lo = ^alu[1:0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (mem_op && !misalign) state_d = ACCESS;
         ACCESS:  if (dmem_ack || cnt_q == CNT_LAST) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus handshake: dmem_req rises with addr/we/wdata valid and holds them
   // until the single-cycle dmem_ack (or the timeout abort); ack in IDLE is ignored.
   always_comb begin
      mem_stall = 1'b0;
      start     = 1'b0;
      finish    = 1'b0;
      cnt_inc   = 1'b0;
      err_set   = 1'b0;
      wb_ld     = 1'b0;
      rd_ld     = 1'b0;
      wb_d      = '{valid:      ex_valid,
                    reg_write:  RegWrite & ex_valid,
                    mem_to_reg: MemtoReg,
                    alu:        alu,
                    mux:        mux};
      case (state_q)
         IDLE: begin
            wb_ld = 1'b1;
            if (mem_op) begin
               wb_d.reg_write = 1'b0;
               if (misalign) begin
                  wb_d.valid = 1'b1;
                  err_set    = 1'b1;
               end else begin
                  wb_d.valid = 1'b0;
                  mem_stall  = 1'b1;
                  start      = 1'b1;
               end
            end
         end
         ACCESS: begin
            if (dmem_ack) begin
               wb_ld          = 1'b1;
               wb_d.valid     = 1'b1;
               wb_d.reg_write = RegWrite;
               rd_ld          = ~dmem_we;
               finish         = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               wb_ld          = 1'b1;
               wb_d.valid     = 1'b1;
               wb_d.reg_write = 1'b0;
               err_set        = 1'b1;
               finish         = 1'b1;
            end else begin
               mem_stall = 1'b1;
               cnt_inc   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         bus_err    <= 1'b0;
      end else begin
         bus_err <= err_set;
         if (start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite;
            dmem_addr  <= {alu[XLEN-1:2], 2'b00};
            dmem_wdata <= readdata2;
         end else if (finish) begin
            dmem_req <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       cnt_q <= '0;
      else if (start)   cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
   end

   mem_wb_reg u_mem_wb_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (wb_ld),
      .d     (wb_d),
      .rd_ld (rd_ld),
      .rd_d  (dmem_rdata),
      .q     (wb_q),
      .rd_q  (readdata_wb)
   );

   assign wb_valid    = wb_q.valid;
   assign RegWrite_wb = wb_q.reg_write;
   assign MemtoReg_wb = wb_q.mem_to_reg;
   assign alu_wb      = wb_q.alu;
   assign mux_wb      = wb_q.mux;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: driver tasks push expected MEM/WB records,
// a negedge monitor pops and compares them whenever wb_valid is presented.
module tb_mem_stage;
   import mips_pkg::*;

   localparam int W = 72;  // {bus_err, rw, mtr, mux[5], alu[32], readdata[32]}

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, branch, jump, MemRead, MemWrite, RegWrite, MemtoReg;
   logic [31:0] adder, alu, readdata2, dmem_rdata;
   logic [1:0]  aluzero;
   logic [4:0]  mux;
   logic        dmem_ack;
   logic [1:0]  pc_sel;
   logic [31:0] pc_target, dmem_addr, dmem_wdata, readdata_wb, alu_wb;
   logic        flush, mem_stall, dmem_req, dmem_we, bus_err;
   logic        wb_valid, RegWrite_wb, MemtoReg_wb;
   logic [4:0]  mux_wb;
   state_t      state_dbg;

   logic [W-1:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] last_rd  = 32'h0;

   mem_stage #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .branch(branch), .jump(jump),
      .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
      .adder(adder), .aluzero(aluzero), .alu(alu), .readdata2(readdata2), .mux(mux),
      .pc_sel(pc_sel), .pc_target(pc_target), .flush(flush), .mem_stall(mem_stall),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .bus_err(bus_err), .wb_valid(wb_valid), .RegWrite_wb(RegWrite_wb),
      .MemtoReg_wb(MemtoReg_wb), .readdata_wb(readdata_wb), .alu_wb(alu_wb),
      .mux_wb(mux_wb), .state_dbg(state_dbg)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] rec(input logic err, input logic rw, input logic mtr,
                                        input logic [4:0] m, input logic [31:0] a,
                                        input logic [31:0] rd);
      return {err, rw, mtr, m, a, rd};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ex_valid = 0; branch = 0; jump = 0; MemRead = 0; MemWrite = 0;
      RegWrite = 0; MemtoReg = 0; adder = 0; aluzero = 0; alu = 0;
      readdata2 = 0; mux = 0; dmem_ack = 0; dmem_rdata = 0;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (wb_valid) begin
            logic [W-1:0] got, exp;
            got = {bus_err, RegWrite_wb, MemtoReg_wb, mux_wb, alu_wb, readdata_wb};
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL wb_unexpected: got %h expected no retire", got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  n_fail++;
                  $display("FAIL wb_record: got %h expected %h", got, exp);
               end
            end
         end else if (bus_err) begin
            n_checks++;
            n_fail++;
            $display("FAIL bus_err_no_wb: got bus_err=1 wb_valid=0 expected wb_valid=1");
         end
      end
   end

   // non-memory instruction, optionally with branch/jump
   task automatic alu_op(input logic [31:0] a, input logic [4:0] m, input logic rw,
                         input logic mtr, input logic br, input logic jmp,
                         input logic [1:0] az, input logic [31:0] tgt,
                         input logic [1:0] exp_pc);
      ex_valid = 1; MemRead = 0; MemWrite = 0;
      alu = a; mux = m; RegWrite = rw; MemtoReg = mtr;
      branch = br; jump = jmp; aluzero = az; adder = tgt;
      #1;
      check("pc_sel", 32'(pc_sel), 32'(exp_pc));
      check("flush", 32'(flush), 32'(exp_pc != 2'b00));
      check("pc_target", pc_target, tgt);
      check("stall_nonmem", 32'(mem_stall), 32'd0);
      exp_q.push_back(rec(1'b0, rw, mtr, m, a, last_rd));
      tick();
      ex_valid = 0; branch = 0; jump = 0;
   endtask

   // memory instruction; ack_after = ACCESS cycles before ack (-1 = never)
   task automatic mem_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [4:0] m, input logic rw,
                             input logic mtr, input int ack_after,
                             input logic [31:0] rdata);
      int req_cycles = 0;
      int stalls = 0;
      bit done = 0;
      int exp_req, exp_stall;
      ex_valid = 1; MemRead = rd; MemWrite = wr; alu = a; readdata2 = wd;
      mux = m; RegWrite = rw; MemtoReg = mtr;
      if (ack_after < 0) begin
         exp_q.push_back(rec(1'b1, 1'b0, mtr, m, a, last_rd));
         exp_req = 16; exp_stall = 16;
      end else begin
         if (!wr) last_rd = rdata;
         exp_q.push_back(rec(1'b0, rw, mtr, m, a, last_rd));
         exp_req = ack_after + 1; exp_stall = ack_after + 1;
      end
      #1;
      if (mem_stall) stalls++;
      tick();
      for (int c = 0; c < 40 && !done; c++) begin
         if (!dmem_req) begin
            done = 1;
            ex_valid = 0; MemRead = 0; MemWrite = 0;
         end else begin
            req_cycles++;
            check("dmem_addr", dmem_addr, {a[31:2], 2'b00});
            check("dmem_we", 32'(dmem_we), 32'(wr));
            check("dmem_wdata", dmem_wdata, wd);
            if (c == ack_after) begin
               dmem_ack = 1; dmem_rdata = rdata;
            end
            #1;
            if (mem_stall) stalls++;
            tick();
            dmem_ack = 0;
         end
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL req_drop_bound: got dmem_req still high expected drop within 40 cycles");
         ex_valid = 0;
      end
      check("req_cycles", 32'(req_cycles), 32'(exp_req));
      check("stall_cycles", 32'(stalls), 32'(exp_stall));
      if (ack_after < 0) begin
         check("bus_err_pulse", 32'(bus_err), 32'd1);
         tick();
         check("bus_err_clear", 32'(bus_err), 32'd0);
      end
   endtask

   initial begin
      clear_inputs();
      rst_n = 0;
      tick(); tick();
      check("rst_req", 32'(dmem_req), 32'd0);
      check("rst_we", 32'(dmem_we), 32'd0);
      check("rst_addr", dmem_addr, 32'd0);
      check("rst_wdata", dmem_wdata, 32'd0);
      check("rst_bus_err", 32'(bus_err), 32'd0);
      check("rst_wb_ctl", {29'd0, wb_valid, RegWrite_wb, MemtoReg_wb}, 32'd0);
      check("rst_wb_data", readdata_wb | alu_wb | 32'(mux_wb), 32'd0);
      check("rst_state", 32'(state_dbg), 32'(IDLE));
      rst_n = 1;
      tick();

      alu_op(32'h1111_0000, 5'd5, 1, 0, 0, 0, 2'b00, 32'h0000_0010, PC_SEQ);
      alu_op(32'h0000_0001, 5'd6, 0, 0, 1, 0, 2'b01, 32'h0000_0040, PC_BR);
      alu_op(32'h0000_0002, 5'd7, 0, 0, 1, 1, 2'b01, 32'h0000_0080, PC_JMP);
      alu_op(32'h0000_0003, 5'd8, 1, 0, 1, 0, 2'b00, 32'h0000_00C0, PC_SEQ);
      alu_op(32'h0000_0004, 5'd9, 1, 1, 1, 0, 2'b10, 32'h0000_0100, PC_SEQ);

      ex_valid = 0; jump = 1; branch = 1; aluzero = 2'b01;
      #1;
      check("pc_sel_invalid", 32'(pc_sel), 32'(PC_SEQ));
      check("flush_invalid", 32'(flush), 32'd0);
      jump = 0; branch = 0; aluzero = 0;
      tick();

      mem_access(1, 0, 32'h0000_0100, 32'h0, 5'd8, 1, 1, 0, 32'hDEAD_BEEF);
      mem_access(0, 1, 32'h0000_0204, 32'h1234_5678, 5'd0, 0, 0, 2, 32'h5555_5555);
      mem_access(1, 1, 32'h0000_0208, 32'hA5A5_A5A5, 5'd2, 0, 0, 0, 32'hFFFF_FFFF);
      mem_access(1, 0, 32'h0000_0400, 32'h0, 5'd4, 1, 1, -1, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
      ex_valid = 1; MemRead = 1; alu = 32'h0000_0102; mux = 5'd7; RegWrite = 1; MemtoReg = 1;
      exp_q.push_back(rec(1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0102, last_rd));
      #1;
      check("align_stall", 32'(mem_stall), 32'd0);
      tick();
      check("align_no_req", 32'(dmem_req), 32'd0);
      check("align_bus_err", 32'(bus_err), 32'd1);
      ex_valid = 0; MemRead = 0;
      tick();
      check("align_bus_err_clear", 32'(bus_err), 32'd0);
`else
      mem_access(1, 0, 32'h0000_0102, 32'h0, 5'd7, 1, 1, 0, 32'hCAFE_F00D);
`endif

      alu_op(32'h0000_BEEF, 5'd31, 1, 0, 0, 0, 2'b00, 32'h0, PC_SEQ);

      ex_valid = 1; MemRead = 1; alu = 32'h0000_0300; mux = 5'd3; RegWrite = 1;
      tick();
      tick();
      check("pre_rst_req", 32'(dmem_req), 32'd1);
      rst_n = 0;
      #1;
      check("midrst_req", 32'(dmem_req), 32'd0);
      check("midrst_state", 32'(state_dbg), 32'(IDLE));
      check("midrst_wb_ctl", {29'd0, wb_valid, RegWrite_wb, MemtoReg_wb}, 32'd0);
      check("midrst_wb_data", readdata_wb | alu_wb | 32'(mux_wb), 32'd0);
      clear_inputs();
      last_rd = 32'h0;
      #2;
      rst_n = 1;
      tick();
      dmem_ack = 1; dmem_rdata = 32'h0000_0BAD;
      #1;
      check("late_ack_stall", 32'(mem_stall), 32'd0);
      tick();
      dmem_ack = 0;
      check("late_ack_req", 32'(dmem_req), 32'd0);
      check("late_ack_state", 32'(state_dbg), 32'(IDLE));
      check("late_ack_rd", readdata_wb, last_rd);
      check("late_ack_wb_valid", 32'(wb_valid), 32'd0);

      tick(); tick();
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
